// File: rtl/sccb_target.sv
// sccb_target: write-only SCCB slave decoding 3-phase writes (ID, sub-address, data) from an oversampled bus.
module sccb_target #(
  parameter logic [7:0] DEV_ID = 8'h42
) (
  input  logic        clk_25M,
  input  logic        rst_25M,
  input  logic        scl,
  input  logic        sda,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic [7:0]  sub_addr,
  output logic        busy,
  output logic        id_err,
  output logic [15:0] wr_count
);
  typedef enum logic [2:0] {S_IDLE, S_DEV_ID, S_SUB_ADDR, S_WR_DATA, S_WAIT_STOP} state_t;
  state_t state, state_n;
  logic [1:0] scl_q, sda_q;
  logic scl_p, sda_p, scl_s, sda_s;
  logic start_ev, stop_ev, shift, phase_end, wr_n, id_err_n, sub_ld;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  assign scl_s = scl_q[1];
  assign sda_s = sda_q[1];
  assign start_ev = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_ev = scl_s & scl_p & ~sda_p & sda_s;
  assign shift = scl_s & ~scl_p & (state inside {S_DEV_ID, S_SUB_ADDR, S_WR_DATA});
  assign phase_end = shift & (cnt == 4'd8);
  assign wr_n = phase_end & (state == S_WR_DATA);
  assign sub_ld = phase_end & (state == S_SUB_ADDR);
  assign id_err_n = phase_end & (state == S_DEV_ID) & (shreg != DEV_ID);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    if (stop_ev) begin
      state_n = S_IDLE;
      cnt_n = 4'd0;
    end else if (start_ev) begin
      state_n = S_DEV_ID;
      cnt_n = 4'd0;
    end else if (phase_end) begin
      cnt_n = 4'd0;
      state_n = state == S_DEV_ID ? (shreg == DEV_ID ? S_SUB_ADDR : S_WAIT_STOP) :
                state == S_SUB_ADDR ? S_WR_DATA : S_WAIT_STOP;
    end else if (shift) begin
      cnt_n = cnt + 4'd1;
      shreg_n = {shreg[6:0], sda_s};
    end
  end
  always_ff @(posedge clk_25M) begin
    if (rst_25M) begin
      scl_q <= 2'b11;
      sda_q <= 2'b11;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
      state <= S_IDLE;
      cnt <= 4'd0;
      shreg <= 8'd0;
      busy <= 1'b0;
      wr_valid <= 1'b0;
      id_err <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      sub_addr <= 8'd0;
      wr_count <= 16'd0;
    end else begin
      scl_q <= {scl_q[0], scl};
      sda_q <= {sda_q[0], sda};
      scl_p <= scl_s;
      sda_p <= sda_s;
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      busy <= state_n != S_IDLE;
      wr_valid <= wr_n;
      id_err <= id_err_n;
      if (sub_ld) sub_addr <= shreg;
      if (wr_n) begin
        wr_addr <= sub_addr;
        wr_data <= shreg;
        wr_count <= wr_count + 16'(wr_count != 16'hFFFF);
      end
    end
  end
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed SCCB write sequences against sccb_target with immediate-assertion checks.
module tb_sccb_target;
  logic clk_25M = 1'b0;
  logic rst_25M = 1'b1;
  logic scl = 1'b1;
  logic sda = 1'b1;
  logic wr_valid, busy, id_err;
  logic [7:0] wr_addr, wr_data, sub_addr;
  logic [15:0] wr_count;
  int checks = 0;
  int failures = 0;
  int nv = 0;
  int ne = 0;
  int nv0, ne0;
  int q = 200;

  sccb_target #(.DEV_ID(8'h42)) dut (
    .clk_25M(clk_25M), .rst_25M(rst_25M), .scl(scl), .sda(sda),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .sub_addr(sub_addr),
    .busy(busy), .id_err(id_err), .wr_count(wr_count)
  );

  always #20 clk_25M = ~clk_25M;

  always @(negedge clk_25M) begin
    if (wr_valid) nv++;
    if (id_err) ne++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda = 1'b1; #(q);
    scl = 1'b1; #(q);
    sda = 1'b0; #(q);
    scl = 1'b0; #(q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; #(q);
    scl = 1'b1; #(q);
    sda = 1'b1; #(q);
  endtask

  task automatic send_bit(input logic b);
    sda = b; #(q);
    scl = 1'b1; #(2 * q);
    scl = 1'b0; #(q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(dc);
  endtask

  task automatic partial(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send_bit(b[7 - i]);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk_25M);
  endtask

  task automatic mark();
    nv0 = nv;
    ne0 = ne;
  endtask

  initial begin
    repeat (3) @(negedge clk_25M);
    rst_25M = 1'b0;
    @(negedge clk_25M);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_wr_valid", 16'(wr_valid), 16'h0);
    chk("rst_id_err", 16'(id_err), 16'h0);
    chk("rst_wr_count", wr_count, 16'h0);
    chk("rst_sub_addr", 16'(sub_addr), 16'h0);
    chk("rst_wr_addr_data", {wr_addr, wr_data}, 16'h0);

    q = 2500;
    mark();
    bus_start();
    settle();
    chk("t1_busy_mid", 16'(busy), 16'h1);
    send_byte(8'h42, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h80, 1'b0);
    bus_stop();
    settle();
    chk("t1_wr_pulses", 16'(nv - nv0), 16'd1);
    chk("t1_id_err_pulses", 16'(ne - ne0), 16'd0);
    chk("t1_wr_addr", 16'(wr_addr), 16'h12);
    chk("t1_wr_data", 16'(wr_data), 16'h80);
    chk("t1_wr_count", wr_count, 16'd1);
    chk("t1_busy_after", 16'(busy), 16'h0);

    q = 200;
    mark();
    bus_start();
    send_byte(8'h43, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h80, 1'b0);
    bus_stop();
    settle();
    chk("t2_id_err_pulses", 16'(ne - ne0), 16'd1);
    chk("t2_wr_pulses", 16'(nv - nv0), 16'd0);
    chk("t2_sub_addr", 16'(sub_addr), 16'h12);
    chk("t2_wr_count", wr_count, 16'd1);

    mark();
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h0A, 1'b0);
    bus_stop();
    settle();
    chk("t3_wr_pulses", 16'(nv - nv0), 16'd0);
    chk("t3_sub_addr", 16'(sub_addr), 16'h0A);
    chk("t3_wr_addr", 16'(wr_addr), 16'h12);
    chk("t3_wr_data", 16'(wr_data), 16'h80);

    mark();
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h55, 1'b1);
    partial(8'hF0, 4);
    bus_stop();
    settle();
    chk("t4_wr_pulses", 16'(nv - nv0), 16'd0);
    chk("t4_busy", 16'(busy), 16'h0);
    chk("t4_wr_count", wr_count, 16'd1);
    chk("t4_sub_addr", 16'(sub_addr), 16'h55);

    mark();
    bus_start();
    send_byte(8'h42, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h80, 1'b1);
    bus_stop();
    settle();
    chk("t4b_wr_pulses", 16'(nv - nv0), 16'd1);
    chk("t4b_wr_addr_data", {wr_addr, wr_data}, 16'h1280);
    chk("t4b_wr_count", wr_count, 16'd2);

    mark();
    bus_start();
    send_byte(8'h42, 1'b0);
    partial(8'h77, 4);
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h3A, 1'b0);
    send_byte(8'h04, 1'b0);
    bus_stop();
    settle();
    chk("t5_wr_pulses", 16'(nv - nv0), 16'd1);
    chk("t5_wr_addr", 16'(wr_addr), 16'h3A);
    chk("t5_wr_data", 16'(wr_data), 16'h04);
    chk("t5_wr_count", wr_count, 16'd3);

    mark();
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h11, 1'b0);
    partial(8'h22, 3);
    @(negedge clk_25M);
    rst_25M = 1'b1;
    @(negedge clk_25M);
    rst_25M = 1'b0;
    @(negedge clk_25M);
    chk("t6_rst_wr_count", wr_count, 16'd0);
    chk("t6_rst_sub_addr", 16'(sub_addr), 16'h0);
    chk("t6_rst_wr_addr_data", {wr_addr, wr_data}, 16'h0);
    chk("t6_rst_busy", 16'(busy), 16'h0);
    bus_stop();
    settle();
    chk("t6_abort_wr_pulses", 16'(nv - nv0), 16'd0);
    mark();
    bus_start();
    send_byte(8'h42, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    bus_stop();
    settle();
    chk("t6_wr_pulses", 16'(nv - nv0), 16'd1);
    chk("t6_wr_count", wr_count, 16'd1);
    chk("t6_wr_addr_data", {wr_addr, wr_data}, 16'h1122);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
